rf_sb: RTL
==========

Name: rf_sb

Overview:
- Parametrised register file with integrated scoreboard for the pipelined core. Successor to the single-write-port RF.
- Provides two asynchronous read ports, two synchronous writeback ports with fixed priority, and optional write-to-read bypass.
- Keeps a per-register pending-write counter so decode can detect RAW hazards (busy) and the issue stage can detect WAW counter overflow (ready).
- Sits between decode/issue (reads, issue) and the writeback stage(s).

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers; power of 2, at least 2; address width AW = clog2(NREGS).
- CNT_W, 2, width of each per-register pending counter; maximum count CMAX = 2^CNT_W - 1.
- BYPASS_EN, 0, 1 = same-cycle writeback data and counter decrements are visible on the read ports.
- ZERO_REG, 1, 1 = register 0 is hardwired: reads 0, is never busy, ignores writes and issues.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous, active-high reset.
- i_rs1_raddr  in  AW  read port 1 address.
- o_rs1_rdata  out  XLEN  read port 1 data (combinational).
- o_rs1_busy  out  1  read port 1 register has an outstanding write.
- i_rs2_raddr  in  AW  read port 2 address.
- o_rs2_rdata  out  XLEN  read port 2 data (combinational).
- o_rs2_busy  out  1  read port 2 register has an outstanding write.
- i_iss_valid  in  1  issue of an instruction that will write i_iss_rd.
- i_iss_rd  in  AW  destination register of the issue.
- o_iss_ready  out  1  the issue is accepted this cycle.
- i_wb0_en  in  1  writeback port 0 enable (high priority).
- i_wb0_addr  in  AW  writeback port 0 address.
- i_wb0_data  in  XLEN  writeback port 0 data.
- i_wb1_en  in  1  writeback port 1 enable (low priority).
- i_wb1_addr  in  AW  writeback port 1 address.
- i_wb1_data  in  XLEN  writeback port 1 data.

Behaviour:
- Reset (synchronous, i_rst=1 at posedge):
  - All registers and all counters are set to 0.
  - Issue and writeback inputs in that cycle are ignored.
  - After reset: rdata=0, busy=0, o_iss_ready=1.
- Storage writes at posedge:
  - wbN_en=1 writes wbN_data to wbN_addr.
  - Both ports enabled to the same address: port 0 data is stored.
  - ZERO_REG=1: writes to address 0 are discarded.
- Reads are combinational from storage.
  - ZERO_REG=1 and address 0: rdata=0 and busy=0 in all cases.
- Bypass (BYPASS_EN=1):
  - A read address matching an enabled wb port (non-zero address when ZERO_REG=1) returns that port's data.
  - If both ports match, port 0 data is returned.
- Counters, per register r:
  - inc = 1 when i_iss_valid & o_iss_ready & i_iss_rd==r.
  - dec = number of enabled wb ports with address r (0..2).
  - Next count = max(cnt + inc - dec, 0), so no underflow.
  - A writeback to a register with cnt=0 still writes data; the count stays 0.
- Busy outputs:
  - BYPASS_EN=0: busy = cnt != 0.
  - BYPASS_EN=1: busy = max(cnt - dec, 0) != 0. Same-cycle issue is not counted.
- o_iss_ready = !(cnt[i_iss_rd] == CMAX && dec[i_iss_rd] == 0).
  - It is combinational and independent of i_iss_valid.
  - It is 1 for rd=0 when ZERO_REG=1; in that case the issue is accepted with no count change.
- Simultaneous issue and single writeback to the same register: net count unchanged.
- Reset asserted mid-operation discards all pending counts; later writebacks of pre-reset work do not underflow (saturate at 0).

Test Plan:
- Reset, then read r1..r31 on both ports -> all rdata=0, busy=0, o_iss_ready=1.
- wb0 writes r5=0xDEADBEEF; next cycle read rs1=5, rs2=0 -> rs1=0xDEADBEEF, rs2=0. A write of 0x1234 to r0 leaves r0 reading 0.
- Same cycle wb0 r7=0xAAAA0000 and wb1 r7=0x5555FFFF:
  - BYPASS_EN=1: same-cycle read of r7 gives 0xAAAA0000.
  - Stored value next cycle is 0xAAAA0000.
  - BYPASS_EN=0: same-cycle read returns the old value 0.
- Scoreboard fill (CNT_W=2):
  - Issue rd=3 three times -> busy(r3)=1 and o_iss_ready=0 for rd=3.
  - A fourth issue is not counted.
  - Issue + wb to r3 in the same cycle keeps count 3; ready=1 in that cycle.
  - Three wbs to r3 -> busy=0.
- Underflow: wb1 to r9 with cnt=0 -> data written, busy(r9)=0, later issue then wb gives busy 1 then 0.
- Mid-operation reset with cnt(r4)=2 -> after reset busy=0, rdata=0. A later wb to r4 writes data and leaves busy=0.

Source files
------------

// File: rtl/rf_sb.sv
// rtl/rf_sb.sv - register file with dual writeback ports and per-register pending-write scoreboard
module rf_sb #(
    parameter  int XLEN      = 32,
    parameter  int NREGS     = 32,
    parameter  int CNT_W     = 2,
    parameter  int BYPASS_EN = 0,
    parameter  int ZERO_REG  = 1,
    localparam int AW        = $clog2(NREGS)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [AW-1:0]   i_rs1_raddr,
    output logic [XLEN-1:0] o_rs1_rdata,
    output logic            o_rs1_busy,
    input  logic [AW-1:0]   i_rs2_raddr,
    output logic [XLEN-1:0] o_rs2_rdata,
    output logic            o_rs2_busy,
    input  logic            i_iss_valid,
    input  logic [AW-1:0]   i_iss_rd,
    output logic            o_iss_ready,
    input  logic            i_wb0_en,
    input  logic [AW-1:0]   i_wb0_addr,
    input  logic [XLEN-1:0] i_wb0_data,
    input  logic            i_wb1_en,
    input  logic [AW-1:0]   i_wb1_addr,
    input  logic [XLEN-1:0] i_wb1_data
);

    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [XLEN-1:0]  regs    [NREGS];
    logic [CNT_W-1:0] cnt     [NREGS];
    logic [CNT_W-1:0] cnt_nxt [NREGS];
    logic [1:0]       dec     [NREGS];

    logic [AW-1:0]    rd_addr [2];
    logic [XLEN-1:0]  rd_data [2];
    logic             rd_busy [2];

    logic             iss_zero;
    logic             wb0_zero;
    logic             wb1_zero;

    assign iss_zero = (ZERO_REG != 0) && (i_iss_rd == '0);
    assign wb0_zero = (ZERO_REG != 0) && (i_wb0_addr == '0);
    assign wb1_zero = (ZERO_REG != 0) && (i_wb1_addr == '0);

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            dec[r] = {1'b0, i_wb0_en && (i_wb0_addr == AW'(r))}
                   + {1'b0, i_wb1_en && (i_wb1_addr == AW'(r))};
        end
    end

    // A writeback in the same cycle frees a slot, so a full counter can still accept.
    assign o_iss_ready = iss_zero || !((cnt[i_iss_rd] == CMAX) && (dec[i_iss_rd] == 2'd0));

    always_comb begin
        logic             inc;
        logic [CNT_W:0]   sum;
        logic [CNT_W:0]   dec_w;
        for (int r = 0; r < NREGS; r++) begin
            inc   = i_iss_valid && o_iss_ready && (i_iss_rd == AW'(r));
            sum   = {1'b0, cnt[r]} + (CNT_W+1)'(inc);
            dec_w = (CNT_W+1)'(dec[r]);
            cnt_nxt[r] = (sum > dec_w) ? CNT_W'(sum - dec_w) : '0;
            if ((ZERO_REG != 0) && (r == 0)) begin
                cnt_nxt[r] = '0;
            end
        end
    end

    assign rd_addr[0] = i_rs1_raddr;
    assign rd_addr[1] = i_rs2_raddr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = (cnt[rd_addr[p]] != '0);
            if (BYPASS_EN != 0) begin
                if (i_wb1_en && (i_wb1_addr == rd_addr[p])) begin
                    rd_data[p] = i_wb1_data;
                end
                if (i_wb0_en && (i_wb0_addr == rd_addr[p])) begin
                    rd_data[p] = i_wb0_data;
                end
                rd_busy[p] = ({1'b0, cnt[rd_addr[p]]} > (CNT_W+1)'(dec[rd_addr[p]]));
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign o_rs1_rdata = rd_data[0];
    assign o_rs1_busy  = rd_busy[0];
    assign o_rs2_rdata = rd_data[1];
    assign o_rs2_busy  = rd_busy[1];

    // Port 0 is assigned last so it wins when both ports target the same register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            if (i_wb1_en && !wb1_zero) begin
                regs[i_wb1_addr] <= i_wb1_data;
            end
            if (i_wb0_en && !wb0_zero) begin
                regs[i_wb0_addr] <= i_wb0_data;
            end
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
        end
    end

endmodule
